toggle_handshake_responder: RTL
===============================

# toggle_handshake_responder

Receiving end of the team's two-phase (toggle) request/acknowledge link. The sender flips `req_tgl` (T flip-flop style) once per transfer with `req_data` held stable. This block detects each flip, presents the captured word to a local consumer over a valid/ready handshake, then flips `ack_tgl` back to close the transfer. It sits between a toggle-signalling producer and any local valid/ready sink, and counts completed transfers and flags protocol violations.

## Interface

Parameters:
- `WIDTH`, 8, data word width
- `CNT_WIDTH`, 8, width of completed-transfer counter

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_tgl`  in  1  request toggle level from sender; every level change is one new request
- `req_data`  in  WIDTH  request payload, stable from `req_tgl` flip until matching `ack_tgl` flip
- `ack_tgl`  out  1  acknowledge toggle level; flips once per completed transfer
- `out_valid`  out  1  captured word available to consumer
- `out_data`  out  WIDTH  captured word
- `out_ready`  in  1  consumer accepts word when high with `out_valid`
- `evt_count`  out  CNT_WIDTH  completed transfers, modulo 2^CNT_WIDTH
- `overrun`  out  1  sticky flag: sender toggled again before acknowledge

## Operation

- Internal `req_s` = `req_tgl` (or its synchronized copy, see Configuration); `req_prev` register holds last accepted level; `change = req_s ^ req_prev`.
- FSM states: IDLE, HOLD, ACK.
- IDLE: on `change`: `out_data <= req_data`, `req_prev <= req_s`, `out_valid <= 1`, go HOLD. Else stay.
- HOLD: `out_valid` high, `out_data` frozen. On `out_valid && out_ready`: `out_valid <= 0`, go ACK. Else stay, with no timeout.
- ACK: `ack_tgl <= ~ack_tgl`, `evt_count <= evt_count + 1` (wraps 2^CNT_WIDTH-1 -> 0), go IDLE.
- Overrun: in HOLD or ACK, if `change` = 1, set `overrun <= 1`; it stays set until `rst`. The extra toggle is not dropped. It remains pending as `change` and is accepted on return to IDLE. A double toggle during HOLD/ACK cancels itself and produces no event, although `overrun` is still set.
- `req_data` is never synchronized. The sender guarantees stability per the protocol.
- Reset values: `ack_tgl` 0, `out_valid` 0, `out_data` 0, `evt_count` 0, `overrun` 0, `req_prev` 0, synchronizer flops 0, state IDLE.
- Reset mid-operation (HOLD/ACK): transfer discarded, no `ack_tgl` flip. If `req_tgl` is 1 after reset, it is treated as a new request. The link reset policy resets both ends together.

## Timing

- Detection latency (macro off): `req_tgl` flip sampled at edge N -> `out_valid`=1, `out_data` valid after edge N.
- Handshake at edge H (`out_valid`&&`out_ready`) -> `out_valid`=0 after H; `ack_tgl` flips and `evt_count` increments after H+1; earliest next capture at edge H+2.
- Minimum round trip from request to ack, with `out_ready` tied high: 3 edges (capture, handshake, ack).
- `out_valid` never drops without a handshake except on `rst`.
- `rst` has priority over all transitions at the same edge.

## Configuration

- `TOGGLE_RESP_SYNC_EN` defined: `req_tgl` passes through a 2-flop synchronizer (reset 0) before `req_s`. Detection latency grows by 2 edges (flip at edge N -> `out_valid` after N+2). This is for an asynchronous sender.
- Undefined: `req_s` = `req_tgl` directly. The sender must be on `clk`.

## Test plan

- Reset: assert `rst` 2 cycles with `req_tgl`=0 -> all outputs 0, state IDLE. Then `req_tgl`=1, `req_data`=8'hA5, `out_ready`=1 -> `out_valid` one cycle with `out_data`=A5, `ack_tgl`=1 two edges later, `evt_count`=1.
- Backpressure: `out_ready`=0 for 5 cycles after capture of 8'h3C -> `out_valid` and `out_data`=3C held for 5 cycles. `ack_tgl` unchanged until 1 edge after `out_ready` rises.
- Burst: 4 transfers (11, 22, 33, 44), each new toggle issued only after `ack_tgl`==`req_tgl` -> consumer sees 11, 22, 33, 44 in order, `evt_count`=4, `overrun`=0.
- Overrun: toggle `req_tgl` during HOLD (`out_ready`=0) -> `overrun`=1 and stays set. After the handshake, a second event is delivered, and `evt_count` increments by 2 in total.
- Wrap: CNT_WIDTH=2, 5 transfers -> `evt_count` sequence 1,2,3,0,1.
- Mid-operation reset: `rst` during HOLD with `req_tgl`=1 -> `out_valid`=0, `ack_tgl`=0. After reset releases, a new capture occurs. With `TOGGLE_RESP_SYNC_EN` defined, every capture is 2 edges later than without it.

Source files
------------

// File: rtl/toggle_handshake_responder_if.sv
// Link bundle for the toggle request/acknowledge receiver: toggle side plus local valid/ready side.
// slave = responder view, master = sender/consumer view.
interface toggle_handshake_responder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_tgl;
  logic [WIDTH-1:0] req_data;
  logic             ack_tgl;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  req_tgl,
    input  req_data,
    input  out_ready,
    output ack_tgl,
    output out_valid,
    output out_data
  );

  modport master (
    output req_tgl,
    output req_data,
    output out_ready,
    input  ack_tgl,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/toggle_handshake_responder.sv
// Two-phase toggle receiver: captures each req_tgl flip, hands the word out over valid/ready,
// then flips ack_tgl. Define TOGGLE_RESP_SYNC_EN to add a 2-flop synchronizer on req_tgl.
module toggle_handshake_responder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  toggle_handshake_responder_if.slave   link,
  output logic [CNT_WIDTH-1:0]          evt_count,
  output logic                          overrun
);

  typedef enum logic [1:0] {StIdle, StHold, StAck} state_e;

  state_e               state_q, state_d;
  logic                 req_s;
  logic                 req_prev_q, req_prev_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 ack_q, ack_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 change;

`ifdef TOGGLE_RESP_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], link.req_tgl};
    end
  end

  assign req_s = sync_q[1];
`else
  assign req_s = link.req_tgl;
`endif

  // A pending flip stays visible here until IDLE accepts it, so overruns are not lost.
  assign change = req_s ^ req_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_prev_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= req_prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_prev_d  = req_prev_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (change) begin
          out_data_d  = link.req_data;
          req_prev_d  = req_s;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (change) overrun_d = 1'b1;
        if (out_valid_q && link.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAck;
        end
      end
      StAck: begin
        if (change) overrun_d = 1'b1;
        ack_d   = ~ack_q;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign link.ack_tgl   = ack_q;
  assign link.out_valid = out_valid_q;
  assign link.out_data  = out_data_q;
  assign evt_count      = cnt_q;
  assign overrun        = overrun_q;

endmodule
